// File: rtl/im_loader.sv
// Instruction-memory loader: takes a framed byte stream (length, big-endian words,
// XOR trailer), writes words from address 0 upward and holds the CPU while loading.
module im_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] words_written
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        len_hi_p0, hi_byte_p0, csum_p0;
   logic [15:0]       len_p0;
   logic [ADDR_W-1:0] ww_p0;
   logic              vld_p1;
   logic [ADDR_W-1:0] waddr_p1;
   logic [15:0]       wdata_p1;

   logic              xfer, arm, last_word;
   logic [15:0]       len_in;
   logic [ADDR_W-1:0] ww_inc;

   // Word counter never wraps past the memory size.
   function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
      if (v >= ADDR_W'(DEPTH)) return v;
      else                     return v + ADDR_W'(1);
   endfunction

   assign xfer      = in_valid && in_ready;
   assign arm       = start && !abort &&
                      (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
   assign len_in    = {len_hi_p0, in_data};
   assign ww_inc    = sat_inc(ww_p0);
   assign last_word = (ww_inc == ADDR_W'(len_p0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: if (xfer) begin
               if (len_in > 16'(DEPTH))  state_d = S_ERR;
               else if (len_in == 16'd0) state_d = S_CHECK;
               else                      state_d = S_DATA_HI;
            end
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) state_d = last_word ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (xfer) state_d = (in_data == csum_p0) ? S_DONE : S_ERR;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         S_ERR:   err  = 1'b1;
         default: ;
      endcase
   end

   assign cpu_hold = busy;

   // Stage p0: byte capture and running XOR; stage p1: registered memory write.
   // An abort in the same cycle as the low byte suppresses that write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_p0  <= '0;
         len_p0     <= '0;
         hi_byte_p0 <= '0;
         csum_p0    <= '0;
         ww_p0      <= '0;
         vld_p1     <= 1'b0;
         waddr_p1   <= '0;
         wdata_p1   <= '0;
      end else begin
         vld_p1 <= 1'b0;
         if (arm) begin
            csum_p0 <= '0;
            ww_p0   <= '0;
            len_p0  <= '0;
         end else if (xfer && !abort) begin
            if (state_q != S_CHECK) csum_p0 <= csum_p0 ^ in_data;
            case (state_q)
               S_LEN_HI:  len_hi_p0  <= in_data;
               S_LEN_LO:  len_p0     <= len_in;
               S_DATA_HI: hi_byte_p0 <= in_data;
               S_DATA_LO: begin
                  vld_p1   <= 1'b1;
                  waddr_p1 <= ww_p0;
                  wdata_p1 <= {hi_byte_p0, in_data};
                  ww_p0    <= ww_inc;
               end
               default: ;
            endcase
         end
      end
   end

   assign we            = vld_p1;
   assign waddr         = waddr_p1;
   assign wdata         = wdata_p1;
   assign words_written = ww_p0;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table-driven frames with a write scoreboard, plus
// hand sequences for abort, start collisions, full-depth load and async reset.
module tb_im_loader;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready, we, busy, cpu_hold, done, err;
   logic [ADDR_W-1:0] waddr, words_written;
   logic [15:0]       wdata;

   im_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .cpu_hold(cpu_hold),
      .done(done), .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_miss = 0;
   int we_cnt = 0;
   int cyc = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic [63:0] bytes;    // first frame byte in [63:56]
      logic [3:0]  nbytes;
      logic        toggle;
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_ww;
      logic [7:0]  exp_nw;
   } vec_t;

   wr_t        exp_q[$];
   logic [7:0] frame_q[$];
   vec_t       vecs[6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && we) begin
         we_cnt++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_we: got write addr %0h data %0h, required no write", waddr, wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("waddr", 32'(waddr), 32'(e.addr));
            check("wdata", 32'(wdata), 32'(e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit do_push, input wr_t w, output bit ok);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      ok = in_ready;
      if (!ok) begin
         n_vec++;
         n_miss++;
         $display("FAIL byte_timeout: in_ready got 0, required 1 for byte %0h", b);
         in_valid = 1'b0;
         return;
      end
      if (do_push) exp_q.push_back(w);
      @(negedge clk);
   endtask

   task automatic run_frame(input bit toggle);
      bit          ok, is_lo;
      logic [15:0] nw;
      wr_t         w;
      nw = {frame_q[0], frame_q[1]};
      for (int i = 0; i < frame_q.size(); i++) begin
         is_lo = (i >= 2) && (nw <= 16'(DEPTH)) && (i < 2 + 2 * int'(nw)) && ((i % 2) == 1);
         w = '0;
         if (is_lo) begin
            w.addr = 16'((i - 3) / 2);
            w.data = {frame_q[i-1], frame_q[i]};
         end
         if (toggle) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            @(negedge clk);
         end
         send_byte(frame_q[i], is_lo, w, ok);
         if (!ok) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_we"}, 32'(we), 0);
      check({pfx, "_waddr"}, 32'(waddr), 0);
      check({pfx, "_wdata"}, 32'(wdata), 0);
      check({pfx, "_words"}, 32'(words_written), 0);
      check({pfx, "_busy"}, 32'(busy), 0);
      check({pfx, "_cpu_hold"}, 32'(cpu_hold), 0);
      check({pfx, "_done"}, 32'(done), 0);
      check({pfx, "_err"}, 32'(err), 0);
      check({pfx, "_in_ready"}, 32'(in_ready), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit          ok;
      wr_t         w;
      int          c0, w0;
      logic [7:0]  cs, b;

      vecs[0] = '{bytes:64'h0002_012F_012E_0300, nbytes:4'd7, toggle:1'b0, exp_done:1'b1, exp_err:1'b0, exp_ww:16'd2, exp_nw:8'd2};
      vecs[1] = '{bytes:64'h0002_012F_012E_0400, nbytes:4'd7, toggle:1'b0, exp_done:1'b0, exp_err:1'b1, exp_ww:16'd2, exp_nw:8'd2};
      vecs[2] = '{bytes:64'h0021_0000_0000_0000, nbytes:4'd2, toggle:1'b0, exp_done:1'b0, exp_err:1'b1, exp_ww:16'd0, exp_nw:8'd0};
      vecs[3] = '{bytes:64'h0000_0000_0000_0000, nbytes:4'd3, toggle:1'b0, exp_done:1'b1, exp_err:1'b0, exp_ww:16'd0, exp_nw:8'd0};
      vecs[4] = '{bytes:64'h0002_012F_012E_0300, nbytes:4'd7, toggle:1'b1, exp_done:1'b1, exp_err:1'b0, exp_ww:16'd2, exp_nw:8'd2};
      vecs[5] = '{bytes:64'h0001_ABCD_6700_0000, nbytes:4'd5, toggle:1'b0, exp_done:1'b1, exp_err:1'b0, exp_ww:16'd1, exp_nw:8'd1};

      #1 rst_n = 1'b0;
      #2 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         vec_t v;
         v = vecs[k];
         pulse_start();
         check($sformatf("v%0d_busy_on_start", k), 32'(busy), 1);
         frame_q.delete();
         for (int i = 0; i < int'(v.nbytes); i++) frame_q.push_back(v.bytes[63-8*i -: 8]);
         c0 = cyc;
         w0 = we_cnt;
         run_frame(v.toggle);
         if (!v.toggle) check($sformatf("v%0d_cycles", k), 32'(cyc - c0), 32'(v.nbytes));
         check($sformatf("v%0d_done", k), 32'(done), 32'(v.exp_done));
         check($sformatf("v%0d_err", k), 32'(err), 32'(v.exp_err));
         check($sformatf("v%0d_words", k), 32'(words_written), 32'(v.exp_ww));
         check($sformatf("v%0d_cpu_hold", k), 32'(cpu_hold), 0);
         check($sformatf("v%0d_in_ready", k), 32'(in_ready), 0);
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_we_count", k), 32'(we_cnt - w0), 32'(v.exp_nw));
         check($sformatf("v%0d_pending", k), 32'(exp_q.size()), 0);
      end

      // Full-depth frame: exactly DEPTH words is legal.
      frame_q.delete();
      frame_q.push_back(8'h00);
      frame_q.push_back(8'(DEPTH));
      cs = 8'(DEPTH);
      for (int i = 0; i < 2 * DEPTH; i++) begin
         b = 8'($urandom_range(0, 255));
         frame_q.push_back(b);
         cs = cs ^ b;
      end
      frame_q.push_back(cs);
      pulse_start();
      c0 = cyc;
      w0 = we_cnt;
      run_frame(1'b0);
      check("full_cycles", 32'(cyc - c0), 32'(2 * DEPTH + 3));
      check("full_done", 32'(done), 1);
      check("full_words", 32'(words_written), 32'(DEPTH));
      @(negedge clk);
      check("full_we_count", 32'(we_cnt - w0), 32'(DEPTH));
      check("hold_waddr", 32'(waddr), 32'(DEPTH - 1));
      check("hold_wdata", 32'(wdata), 32'({frame_q[2*DEPTH], frame_q[2*DEPTH+1]}));
      check("hold_we", 32'(we), 0);

      // start and abort together from DONE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 32'(busy), 0);
      check("sa_done", 32'(done), 0);
      check("sa_err", 32'(err), 0);
      check("sa_in_ready", 32'(in_ready), 0);

      // start while busy is ignored.
      pulse_start();
      w = '0;
      send_byte(8'h00, 1'b0, w, ok);
      send_byte(8'h01, 1'b0, w, ok);
      in_valid = 1'b0;
      pulse_start();
      send_byte(8'hAB, 1'b0, w, ok);
      w = '{addr:16'h0000, data:16'hABCD};
      send_byte(8'hCD, 1'b1, w, ok);
      send_byte(8'h67, 1'b0, w, ok);
      in_valid = 1'b0;
      check("busy_start_done", 32'(done), 1);
      check("busy_start_words", 32'(words_written), 1);

      // Abort right after the first word: one write, then idle.
      pulse_start();
      w0 = we_cnt;
      w = '0;
      send_byte(8'h00, 1'b0, w, ok);
      send_byte(8'h02, 1'b0, w, ok);
      send_byte(8'h01, 1'b0, w, ok);
      w = '{addr:16'h0000, data:16'h012F};
      send_byte(8'h2F, 1'b1, w, ok);
      in_data = 8'h01;
      abort   = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_err", 32'(err), 0);
      check("abort_in_ready", 32'(in_ready), 0);
      repeat (4) @(negedge clk);
      check("abort_we_count", 32'(we_cnt - w0), 1);
      check("abort_pending", 32'(exp_q.size()), 0);

      // Async reset in the middle of DATA_LO, between clock edges.
      pulse_start();
      w = '0;
      send_byte(8'h00, 1'b0, w, ok);
      send_byte(8'h02, 1'b0, w, ok);
      send_byte(8'h01, 1'b0, w, ok);
      w = '{addr:16'h0000, data:16'h012F};
      send_byte(8'h2F, 1'b1, w, ok);
      w = '0;
      send_byte(8'h01, 1'b0, w, ok);
      in_valid = 1'b0;
      check("pre_rst_words", 32'(words_written), 1);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      w0 = we_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_we_count", 32'(we_cnt - w0), 0);

      pulse_start();
      frame_q.delete();
      for (int i = 0; i < 7; i++) frame_q.push_back(vecs[0].bytes[63-8*i -: 8]);
      w0 = we_cnt;
      run_frame(1'b0);
      check("reload_done", 32'(done), 1);
      check("reload_err", 32'(err), 0);
      check("reload_words", 32'(words_written), 2);
      @(negedge clk);
      check("reload_we_count", 32'(we_cnt - w0), 2);
      check("reload_pending", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
Writer side of the instruction memory. Accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words high byte first, and issues single-cycle writes to the instruction memory array at consecutive addresses starting at 0. While a load is in progress it holds the CPU in reset through cpu_hold, and it reports done or err when the frame ends.

Parameters:
DEPTH, 32, number of instruction memory words; the largest legal frame length.
ADDR_W, 16, width of waddr and of the word counters; matches the PC width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that arms a new load
abort  input  1  one-cycle pulse that cancels the current load
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte
we  output  1  instruction memory write enable, one-cycle pulse
waddr  output  ADDR_W  write address
wdata  output  16  write data
busy  output  1  a load is in progress
cpu_hold  output  1  CPU held in reset; equal to busy
done  output  1  frame loaded with a good checksum (sticky)
err  output  1  frame rejected (sticky)
words_written  output  ADDR_W  number of words written in the current or last load

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs 0; waddr, wdata and words_written are 0.
  - The running checksum and length registers clear.
  - A reset mid-load stops all writes immediately. Words already written stay in memory.
- Frame format:
  - LEN_HI, LEN_LO: the 16-bit word count N.
  - N pairs of bytes: HI, LO.
  - One checksum byte: XOR of every preceding byte of the frame, including the length bytes.
- Handshake:
  - A byte transfers on any clk edge with in_valid && in_ready.
  - in_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 in IDLE, DONE and ERR.
  - in_data is ignored when in_ready = 0.
- States:
  - IDLE: start -> LEN_HI. On entry to LEN_HI: busy = 1; done, err, words_written and the checksum clear.
  - LEN_HI: byte accepted -> LEN_LO.
  - LEN_LO: byte accepted:
    - N > DEPTH -> ERR.
    - N = 0 -> CHECK.
    - Otherwise -> DATA_HI.
  - DATA_HI: byte accepted -> DATA_LO; the byte is latched as the high half.
  - DATA_LO: byte accepted; words_written increments on the same edge:
    - -> CHECK if this was word N.
    - -> DATA_HI otherwise.
  - CHECK: byte accepted, compared with the running XOR:
    - Equal -> DONE.
    - Different -> ERR.
  - DONE: done = 1, busy = 0.
  - ERR: err = 1, busy = 0.
  - DONE/ERR + start -> LEN_HI, which clears done/err.
- Write timing:
  - we pulses exactly one cycle, on the cycle after a DATA_LO handshake.
  - waddr = index of that word (0..N-1); wdata = {HI, LO}.
  - waddr and wdata hold their values after the pulse.
  - in_ready stays high during the write, so back-to-back bytes are accepted at one per cycle. Sustained throughput is one word per 2 cycles.
- Abort:
  - From any state, abort -> IDLE; busy, done and err go to 0.
  - A we already registered for the current cycle completes; no later write is issued.
- Simultaneous events:
  - abort and start in the same cycle: abort wins, state = IDLE.
  - start while busy is ignored.
- Checksum mismatch: words already written remain in memory; err = 1 and cpu_hold is released, and software must not run the image.
- words_written saturates at DEPTH and never wraps.

Test Plan:
- Nominal load: start, then bytes 00 02 01 2F 01 2E 03, in_valid held high.
  - we pulses twice: (waddr 0, wdata 0x012F), then (waddr 1, wdata 0x012E).
  - Then done = 1, err = 0, words_written = 2, cpu_hold = 0.
- Bad checksum: same frame with a final byte of 0x04.
  - Both writes still occur; err = 1, done = 0.
- Oversize length with DEPTH = 32: start, then bytes 00 21.
  - No we pulse; err = 1 right after LEN_LO; in_ready = 0.
- Zero length: start, then bytes 00 00 00.
  - No writes; done = 1; words_written = 0.
- Backpressure and abort: toggle in_valid 1/0 every cycle through the nominal frame.
  - Identical writes to the nominal case.
  - In a repeat run, abort right after the first word: exactly one we, then IDLE with busy = 0.
  - start and abort pulsed in the same cycle from DONE: state = IDLE.
- Async reset: assert rst_n = 0 mid-DATA_LO, between clock edges.
  - All outputs are 0 at once; no we after release; the next start loads normally.
